// File: rtl/rob_commit.sv
// rob_commit: in-order dual-slot retirement from the ROB head.
// Frees old mappings, issues at most one store write, counts commits.
module rob_commit #(
  parameter int SIZE     = 32,
  parameter int REG_NUM  = 64,
  parameter int ROB_ROWS = 16,
  parameter int MEM_ROWS = 64,
  parameter int PC_WIDTH = 10,
  localparam int RB = $clog2(ROB_ROWS),
  localparam int RW = $clog2(REG_NUM),
  localparam int AW = $clog2(MEM_ROWS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_en,
  input  logic [ROB_ROWS-1:0]      rob_valid,
  input  logic [ROB_ROWS-1:0]      rob_dest_reg_val_valid,
  input  logic [ROB_ROWS-1:0]      rob_is_sw,
  input  logic [ROB_ROWS*RW-1:0]   rob_old_dest_reg,
  input  logic [ROB_ROWS*AW-1:0]   rob_store_addr,
  input  logic [ROB_ROWS*SIZE-1:0] rob_store_data,
  input  logic [ROB_ROWS*PC_WIDTH-1:0] rob_pc,
  output logic [RB-1:0]            head_robn,
  output logic [1:0]               retire_valid,
  output logic [2*RB-1:0]          retire_robn,
  output logic [1:0]               free_reg_valid,
  output logic [2*RW-1:0]          free_reg,
  output logic                     EnWrite,
  output logic [AW-1:0]            write_addr,
  output logic [SIZE-1:0]          write_data_mem,
  output logic [PC_WIDTH-1:0]      commit_pc,
  output logic [31:0]              retired_count
);

  typedef struct packed {
    logic                rdy;
    logic                sw;
    logic [RW-1:0]       od;
    logic [AW-1:0]       addr;
    logic [SIZE-1:0]     data;
    logic [PC_WIDTH-1:0] pc;
  } slot_t;

  logic [RB-1:0]       idx [2];
  slot_t               sl  [2];
  logic [1:0]          ret;
  logic [1:0]          fre;
  logic [1:0]          nret;
  logic                st_en;
  logic [AW-1:0]       st_addr;
  logic [SIZE-1:0]     st_data;
  logic [PC_WIDTH-1:0] pc_nx;

  assign idx[0] = head_robn;
  assign idx[1] = head_robn + RB'(1);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sl[k].rdy  = rob_valid[idx[k]]
                 & rob_dest_reg_val_valid[idx[k]];
      sl[k].sw   = rob_is_sw[idx[k]];
      sl[k].od   = rob_old_dest_reg[idx[k]*RW +: RW];
      sl[k].addr = rob_store_addr[idx[k]*AW +: AW];
      sl[k].data = rob_store_data[idx[k]*SIZE +: SIZE];
      sl[k].pc   = rob_pc[idx[k]*PC_WIDTH +: PC_WIDTH];
    end
  end

  // Two stores never pair: the memory port takes one write per cycle.
  always_comb begin
    ret[0] = commit_en & sl[0].rdy;
    ret[1] = ret[0] & sl[1].rdy & ~(sl[0].sw & sl[1].sw);
    fre[0] = ret[0] & ~sl[0].sw;
    fre[1] = ret[1] & ~sl[1].sw;
    nret   = {1'b0, ret[0]} + {1'b0, ret[1]};
  end

  always_comb begin
    st_en   = 1'b0;
    st_addr = '0;
    st_data = '0;
    unique case (1'b1)
      ret[0] && sl[0].sw: begin
        st_en   = 1'b1;
        st_addr = sl[0].addr;
        st_data = sl[0].data;
      end
      ret[1] && sl[1].sw: begin
        st_en   = 1'b1;
        st_addr = sl[1].addr;
        st_data = sl[1].data;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_nx = commit_pc;
    if (ret[1])
      pc_nx = sl[1].pc;
    else if (ret[0])
      pc_nx = sl[0].pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_robn      <= '0;
      retire_valid   <= '0;
      retire_robn    <= '0;
      free_reg_valid <= '0;
      free_reg       <= '0;
      EnWrite        <= 1'b0;
      write_addr     <= '0;
      write_data_mem <= '0;
      commit_pc      <= '0;
      retired_count  <= '0;
    end else begin
      head_robn      <= head_robn + RB'(nret);
      retire_valid   <= ret;
      free_reg_valid <= fre;
      EnWrite        <= st_en;
      commit_pc      <= pc_nx;
      retired_count  <= retired_count + 32'(nret);
      if (ret[0])
        retire_robn[RB-1:0] <= idx[0];
      if (ret[1])
        retire_robn[2*RB-1:RB] <= idx[1];
      if (fre[0])
        free_reg[RW-1:0] <= sl[0].od;
      if (fre[1])
        free_reg[2*RW-1:RW] <= sl[1].od;
      if (st_en) begin
        write_addr     <= st_addr;
        write_data_mem <= st_data;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios plus randomized run
// against a simple in-order retirement model.
module tb_rob_commit;

  localparam int N  = 16;
  localparam int RB = 4;
  localparam int RW = 6;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int PW = 10;

  logic clk = 1'b0;
  logic rst;
  logic commit_en;
  logic [N-1:0] v, rdy, sw;
  logic [RW-1:0] od [N];
  logic [AW-1:0] sa [N];
  logic [DW-1:0] sd [N];
  logic [PW-1:0] pcs [N];

  logic [N*RW-1:0] rob_old_dest_reg;
  logic [N*AW-1:0] rob_store_addr;
  logic [N*DW-1:0] rob_store_data;
  logic [N*PW-1:0] rob_pc;

  logic [RB-1:0]   head_robn;
  logic [1:0]      retire_valid;
  logic [2*RB-1:0] retire_robn;
  logic [1:0]      free_reg_valid;
  logic [2*RW-1:0] free_reg;
  logic            EnWrite;
  logic [AW-1:0]   write_addr;
  logic [DW-1:0]   write_data_mem;
  logic [PW-1:0]   commit_pc;
  logic [31:0]     retired_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    rob_old_dest_reg = '0;
    rob_store_addr   = '0;
    rob_store_data   = '0;
    rob_pc           = '0;
    for (int i = 0; i < N; i++) begin
      rob_old_dest_reg[i*RW +: RW] = od[i];
      rob_store_addr[i*AW +: AW]   = sa[i];
      rob_store_data[i*DW +: DW]   = sd[i];
      rob_pc[i*PW +: PW]           = pcs[i];
    end
  end

  rob_commit dut (
    .clk                    (clk),
    .rst                    (rst),
    .commit_en              (commit_en),
    .rob_valid              (v),
    .rob_dest_reg_val_valid (rdy),
    .rob_is_sw              (sw),
    .rob_old_dest_reg       (rob_old_dest_reg),
    .rob_store_addr         (rob_store_addr),
    .rob_store_data         (rob_store_data),
    .rob_pc                 (rob_pc),
    .head_robn              (head_robn),
    .retire_valid           (retire_valid),
    .retire_robn            (retire_robn),
    .free_reg_valid         (free_reg_valid),
    .free_reg               (free_reg),
    .EnWrite                (EnWrite),
    .write_addr             (write_addr),
    .write_data_mem         (write_data_mem),
    .commit_pc              (commit_pc),
    .retired_count          (retired_count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rob();
    v = '0;
    rdy = '0;
    sw = '0;
    for (int i = 0; i < N; i++) begin
      od[i] = '0;
      sa[i] = '0;
      sd[i] = '0;
      pcs[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_rob();
    commit_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_alu(input int i, input int o, input int p);
    v[i] = 1'b1;
    rdy[i] = 1'b1;
    sw[i] = 1'b0;
    od[i] = RW'(o);
    pcs[i] = PW'(p);
  endtask

  task automatic set_st(input int i, input int a,
                        input int d, input int p);
    v[i] = 1'b1;
    rdy[i] = 1'b1;
    sw[i] = 1'b1;
    sa[i] = AW'(a);
    sd[i] = DW'(d);
    pcs[i] = PW'(p);
  endtask

  // The ROB drops entries the cycle it sees them retire.
  task automatic rob_ack();
    for (int k = 0; k < 2; k++)
      if (retire_valid[k]) begin
        v[retire_robn[k*RB +: RB]] = 1'b0;
        rdy[retire_robn[k*RB +: RB]] = 1'b0;
      end
  endtask

  task automatic test_reset();
    clear_rob();
    commit_en = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({head_robn, retire_valid, free_reg_valid, EnWrite} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got %h/%b/%b/%b want 0", head_robn,
               retire_valid, free_reg_valid, EnWrite);
    end
    checks++;
    if ({retire_robn, free_reg, write_addr} !== '0) begin
      errors++;
      $display("FAIL reset_idx: got %h/%h/%h want 0",
               retire_robn, free_reg, write_addr);
    end
    checks++;
    if ({write_data_mem, commit_pc, retired_count} !== '0) begin
      errors++;
      $display("FAIL reset_val: got %h/%h/%h want 0",
               write_data_mem, commit_pc, retired_count);
    end
    rst = 1'b0;
    commit_en = 1'b1;
  endtask

  task automatic test_alu_pair();
    set_alu(0, 5, 0);
    set_alu(1, 7, 1);
    tick();
    checks++;
    if (retire_valid !== 2'b11 || retire_robn !== 8'h10) begin
      errors++;
      $display("FAIL alu_retire: got %b/%h want 11/10",
               retire_valid, retire_robn);
    end
    checks++;
    if (free_reg_valid !== 2'b11 || free_reg !== {6'd7, 6'd5}) begin
      errors++;
      $display("FAIL alu_free: got %b/%h want 11/%h",
               free_reg_valid, free_reg, {6'd7, 6'd5});
    end
    checks++;
    if (commit_pc !== 10'd1 || head_robn !== 4'd2 ||
        retired_count !== 32'd2 || EnWrite !== 1'b0) begin
      errors++;
      $display("FAIL alu_state: got pc %0d head %0d cnt %0d we %b want 1 2 2 0",
               commit_pc, head_robn, retired_count, EnWrite);
    end
    rob_ack();
  endtask

  task automatic test_store_pair();
    set_st(2, 4, 'hA, 2);
    set_st(3, 9, 'hB, 3);
    tick();
    checks++;
    if (EnWrite !== 1'b1 || write_addr !== 6'd4 ||
        write_data_mem !== 32'hA) begin
      errors++;
      $display("FAIL st1_write: got %b %0d %h want 1 4 a",
               EnWrite, write_addr, write_data_mem);
    end
    checks++;
    if (retire_valid !== 2'b01 || free_reg_valid !== 2'b00 ||
        head_robn !== 4'd3 || retired_count !== 32'd3) begin
      errors++;
      $display("FAIL st1_state: got rv %b fv %b head %0d cnt %0d want 01 00 3 3",
               retire_valid, free_reg_valid, head_robn, retired_count);
    end
    rob_ack();
    tick();
    checks++;
    if (EnWrite !== 1'b1 || write_addr !== 6'd9 ||
        write_data_mem !== 32'hB || head_robn !== 4'd4 ||
        commit_pc !== 10'd3) begin
      errors++;
      $display("FAIL st2_write: got %b %0d %h head %0d pc %0d want 1 9 b 4 3",
               EnWrite, write_addr, write_data_mem, head_robn, commit_pc);
    end
    rob_ack();
    tick();
    checks++;
    if (EnWrite !== 1'b0 || write_addr !== 6'd9 ||
        write_data_mem !== 32'hB || retire_valid !== 2'b00 ||
        commit_pc !== 10'd3) begin
      errors++;
      $display("FAIL st_hold: got %b %0d %h rv %b pc %0d want 0 9 b 00 3",
               EnWrite, write_addr, write_data_mem, retire_valid, commit_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) set_alu(i, i, i);
    for (int c = 0; c < 8; c++) begin
      tick();
      rob_ack();
    end
    checks++;
    if (head_robn !== 4'd15 || retired_count !== 32'd15) begin
      errors++;
      $display("FAIL wrap_pre: got head %0d cnt %0d want 15 15",
               head_robn, retired_count);
    end
    set_alu(15, 33, 100);
    set_alu(0, 34, 101);
    tick();
    checks++;
    if (retire_valid !== 2'b11 || retire_robn !== 8'h0F ||
        head_robn !== 4'd1) begin
      errors++;
      $display("FAIL wrap_retire: got %b %h head %0d want 11 0f 1",
               retire_valid, retire_robn, head_robn);
    end
    checks++;
    if (free_reg !== {6'd34, 6'd33} || commit_pc !== 10'd101 ||
        retired_count !== 32'd17) begin
      errors++;
      $display("FAIL wrap_data: got %h pc %0d cnt %0d want %h 101 17",
               free_reg, commit_pc, retired_count, {6'd34, 6'd33});
    end
    rob_ack();
  endtask

  task automatic test_head_not_ready();
    set_alu(1, 20, 200);
    rdy[1] = 1'b0;
    set_alu(2, 21, 201);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (retire_valid !== 2'b00 || head_robn !== 4'd1) begin
        errors++;
        $display("FAIL hnr_stall: got rv %b head %0d want 00 1",
                 retire_valid, head_robn);
      end
    end
    rdy[1] = 1'b1;
    tick();
    checks++;
    if (retire_valid !== 2'b11 || retire_robn !== 8'h21 ||
        head_robn !== 4'd3 || commit_pc !== 10'd201) begin
      errors++;
      $display("FAIL hnr_go: got %b %h head %0d pc %0d want 11 21 3 201",
               retire_valid, retire_robn, head_robn, commit_pc);
    end
    rob_ack();
  endtask

  task automatic test_commit_gate();
    set_alu(3, 40, 300);
    set_alu(4, 41, 301);
    commit_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (retire_valid !== 2'b00 || free_reg_valid !== 2'b00 ||
          head_robn !== 4'd3 || retired_count !== 32'd19) begin
        errors++;
        $display("FAIL gate_hold: got rv %b fv %b head %0d cnt %0d want 00 00 3 19",
                 retire_valid, free_reg_valid, head_robn, retired_count);
      end
    end
    commit_en = 1'b1;
    tick();
    checks++;
    if (retire_valid !== 2'b11 || head_robn !== 4'd5 ||
        retired_count !== 32'd21) begin
      errors++;
      $display("FAIL gate_go: got rv %b head %0d cnt %0d want 11 5 21",
               retire_valid, head_robn, retired_count);
    end
    rob_ack();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 9; i++) set_alu(i, i + 1, i);
    for (int c = 0; c < 5; c++) begin
      tick();
      rob_ack();
    end
    checks++;
    if (retired_count !== 32'd9 || head_robn !== 4'd9) begin
      errors++;
      $display("FAIL mid_pre: got cnt %0d head %0d want 9 9",
               retired_count, head_robn);
    end
    set_alu(9, 50, 9);
    set_st(10, 3, 'h77, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({retire_valid, free_reg_valid, EnWrite} !== '0 ||
        head_robn !== 4'd0 || retired_count !== 32'd0 ||
        commit_pc !== 10'd0 || retire_robn !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst: got rv %b fv %b we %b head %0d cnt %0d pc %0d",
               retire_valid, free_reg_valid, EnWrite, head_robn,
               retired_count, commit_pc);
    end
  endtask

  task automatic test_random();
    int m_head;
    logic [31:0] m_cnt;
    logic [PW-1:0] m_pc;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    do_reset();
    m_head = 0;
    m_cnt = '0;
    m_pc = '0;
    m_wa = '0;
    m_wd = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int h, h1, n;
      bit ok0, ok1, e0, e1, we;
      logic [1:0] x_fv;
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1'b1;
          rdy[i] = 1'($urandom_range(0, 1));
          sw[i] = 1'($urandom_range(0, 1));
          od[i] = RW'($urandom);
          sa[i] = AW'($urandom);
          sd[i] = $urandom;
          pcs[i] = PW'($urandom);
        end else if (v[i] && !rdy[i] && $urandom_range(0, 2) == 0) begin
          rdy[i] = 1'b1;
        end
      end
      commit_en = ($urandom_range(0, 4) != 0);
      h = m_head;
      h1 = (m_head + 1) % N;
      ok0 = v[h] && rdy[h];
      ok1 = v[h1] && rdy[h1];
      e0 = commit_en && ok0;
      e1 = e0 && ok1 && !(sw[h] && sw[h1]);
      n = int'(e0) + int'(e1);
      x_fv = {e1 && !sw[h1], e0 && !sw[h]};
      we = (e0 && sw[h]) || (e1 && sw[h1]);
      if (e0 && sw[h]) begin
        m_wa = sa[h];
        m_wd = sd[h];
      end else if (e1 && sw[h1]) begin
        m_wa = sa[h1];
        m_wd = sd[h1];
      end
      if (e1) m_pc = pcs[h1];
      else if (e0) m_pc = pcs[h];
      m_cnt = m_cnt + 32'(n);
      m_head = (m_head + n) % N;
      tick();
      checks++;
      if (retire_valid !== {e1, e0} || head_robn !== RB'(m_head)) begin
        errors++;
        $display("FAIL rnd_retire c%0d: got rv %b head %0d want %b %0d",
                 cyc, retire_valid, head_robn, {e1, e0}, m_head);
      end
      checks++;
      if ((e0 && retire_robn[RB-1:0] !== RB'(h)) ||
          (e1 && retire_robn[2*RB-1:RB] !== RB'(h1))) begin
        errors++;
        $display("FAIL rnd_robn c%0d: got %h want %0d/%0d",
                 cyc, retire_robn, h, h1);
      end
      checks++;
      if (free_reg_valid !== x_fv ||
          (x_fv[0] && free_reg[RW-1:0] !== od[h]) ||
          (x_fv[1] && free_reg[2*RW-1:RW] !== od[h1])) begin
        errors++;
        $display("FAIL rnd_free c%0d: got %b %h want %b %h/%h",
                 cyc, free_reg_valid, free_reg, x_fv, od[h1], od[h]);
      end
      checks++;
      if (EnWrite !== we || write_addr !== m_wa ||
          write_data_mem !== m_wd) begin
        errors++;
        $display("FAIL rnd_store c%0d: got %b %h %h want %b %h %h",
                 cyc, EnWrite, write_addr, write_data_mem, we, m_wa, m_wd);
      end
      checks++;
      if (commit_pc !== m_pc || retired_count !== m_cnt) begin
        errors++;
        $display("FAIL rnd_pc_cnt c%0d: got %h %0d want %h %0d",
                 cyc, commit_pc, retired_count, m_pc, m_cnt);
      end
      if (e0) begin
        v[h] = 1'b0;
        rdy[h] = 1'b0;
      end
      if (e1) begin
        v[h1] = 1'b0;
        rdy[h1] = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    commit_en = 1'b0;
    clear_rob();
    @(negedge clk);
    test_reset();
    test_alu_pair();
    test_store_pair();
    test_wrap();
    test_head_not_ready();
    test_commit_gate();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
